// File: rtl/sha256_padder.sv
// ============================================================================
//  Module      : sha256_padder
//  Description : Byte-stream front end for SHA-256. It accepts one message
//                byte per beat and applies FIPS 180-4 padding: a 0x80
//                marker, zero fill and a 64-bit big-endian bit length. It
//                emits 512-bit blocks with message byte 0 at [511:504]. Each
//                block carries first/last flags for a chaining core.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                in_valid/in_ready/in_data   - byte input handshake
//                in_last/in_empty            - end of message / no-byte beat
//                blk_valid/blk_ready         - block output handshake
//                blk_data                    - 512-bit padded block
//                blk_first/blk_last          - block position in message
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Extra block still owed after the current one is handed off.
    typedef enum logic [1:0] {
        TAIL_NONE     = 2'd0,
        TAIL_ZERO_LEN = 2'd1,   // zeros + length
        TAIL_MARK_LEN = 2'd2    // 0x80 + zeros + length
    } tail_t;

    state_t         state_q, state_d;
    tail_t          tail_q, tail_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [60:0]    len_q, len_d;
    logic [511:0]   buf_q, buf_d;
    logic           first_pend_q, first_pend_d;
    logic           blk_first_q, blk_first_d;
    logic           blk_last_q, blk_last_d;

    logic [511:0]   wr_buf;
    logic [6:0]     m;
    logic [60:0]    len_inc;
    logic [63:0]    bitlen;

    always_comb begin
        state_d      = state_q;
        tail_d       = tail_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        buf_d        = buf_q;
        first_pend_d = first_pend_q;
        blk_first_d  = blk_first_q;
        blk_last_d   = blk_last_q;

        // Buffer with the current beat's byte written at index cnt.
        wr_buf = buf_q;
        for (int i = 0; i < 64; i++) begin
            if (!in_empty && (cnt_q == 6'(i))) begin
                wr_buf[511 - 8*i -: 8] = in_data;
            end
        end
        m       = {1'b0, cnt_q} + {6'd0, !in_empty};
        len_inc = len_q + {60'd0, !in_empty};
        bitlen  = {len_inc, 3'b000};

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    buf_d = wr_buf;
                    cnt_d = m[5:0];
                    len_d = len_inc;
                    if (in_last) begin
                        state_d      = EMIT;
                        blk_first_d  = first_pend_q;
                        first_pend_d = 1'b0;
                        // Marker lands at byte m when the block has room.
                        for (int i = 0; i < 64; i++) begin
                            if (m == 7'(i)) begin
                                buf_d[511 - 8*i -: 8] = 8'h80;
                            end
                        end
                        if (m <= 7'd55) begin
                            buf_d[63:0] = bitlen;
                            blk_last_d  = 1'b1;
                            tail_d      = TAIL_NONE;
                        end else if (m <= 7'd63) begin
                            blk_last_d  = 1'b0;
                            tail_d      = TAIL_ZERO_LEN;
                        end else begin
                            blk_last_d  = 1'b0;
                            tail_d      = TAIL_MARK_LEN;
                        end
                    end else if (m == 7'd64) begin
                        state_d      = EMIT;
                        blk_first_d  = first_pend_q;
                        first_pend_d = 1'b0;
                        blk_last_d   = 1'b0;
                        tail_d       = TAIL_NONE;
                    end
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    case (tail_q)
                        TAIL_ZERO_LEN: begin
                            buf_d       = {448'd0, len_q, 3'b000};
                            blk_first_d = 1'b0;
                            blk_last_d  = 1'b1;
                            tail_d      = TAIL_NONE;
                        end
                        TAIL_MARK_LEN: begin
                            buf_d       = {8'h80, 440'd0, len_q, 3'b000};
                            blk_first_d = 1'b0;
                            blk_last_d  = 1'b1;
                            tail_d      = TAIL_NONE;
                        end
                        default: begin
                            // Clearing the buffer keeps old bytes out of the
                            // unwritten positions of the next block.
                            state_d = FILL;
                            cnt_d   = 6'd0;
                            buf_d   = '0;
                            if (blk_last_q) begin
                                len_d        = '0;
                                first_pend_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            tail_q       <= TAIL_NONE;
            cnt_q        <= 6'd0;
            len_q        <= '0;
            buf_q        <= '0;
            first_pend_q <= 1'b1;
            blk_first_q  <= 1'b0;
            blk_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            first_pend_q <= first_pend_d;
            blk_first_q  <= blk_first_d;
            blk_last_q   <= blk_last_d;
        end
    end

    // Gating with rst forces idle outputs while reset is held. Gating the
    // block fields with blk_valid hides the partially filled buffer.
    assign in_ready  = (state_q == FILL) && !rst;
    assign blk_valid = (state_q == EMIT) && !rst;
    assign blk_data  = blk_valid ? buf_q : '0;
    assign blk_first = blk_valid && blk_first_q;
    assign blk_last  = blk_valid && blk_last_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none

module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected block scoreboard.
    logic [511:0] exp_data[$];
    logic         exp_first[$];
    logic         exp_last[$];

    always #5 clk = ~clk;

    sha256_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    // Reference: build the whole padded byte stream, then slice into blocks.
    task automatic add_expected(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nb;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = p[64*b + i];
            exp_data.push_back(blk);
            exp_first.push_back(b == 0);
            exp_last.push_back(b == nb - 1);
        end
    endtask

    task automatic clear_expected();
        exp_data.delete();
        exp_first.delete();
        exp_last.delete();
    endtask

    task automatic rand_msg(input int n, output logic [7:0] msg[$]);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(255)));
    endtask

    task automatic abc_msg(output logic [7:0] msg[$]);
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic e,
                             input int gap_pct);
        logic acc;
        int   guard;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(255));
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_empty = e;
        guard    = 0;
        acc      = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (guard > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_accept_timeout: in_ready got %0b, need 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic drive_msg(input logic [7:0] msg[$], input logic trailing,
                             input int gap_pct);
        int n;
        n = msg.size();
        if (n == 0) begin
            send_beat(8'h00, 1'b1, 1'b1, gap_pct);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (gap_pct > 0 && $urandom_range(99) < 5)
                    send_beat(8'h5A, 1'b0, 1'b1, gap_pct);
                send_beat(msg[i], (i == n - 1) && !trailing, 1'b0, gap_pct);
            end
            if (trailing) send_beat(8'hC3, 1'b1, 1'b1, gap_pct);
        end
    endtask

    // Pops and checks every handshaken block. Also checks that the block
    // fields stay stable while the output is stalled.
    task automatic collect(input int stall_pct, input int max_cycles);
        int           cyc;
        logic         prev_stall;
        logic [511:0] pd;
        logic         pf, pl;
        cyc        = 0;
        prev_stall = 1'b0;
        pd = '0; pf = 1'b0; pl = 1'b0;
        while (exp_data.size() > 0 && cyc < max_cycles) begin
            blk_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (blk_valid !== 1'b1 || blk_data !== pd || blk_first !== pf || blk_last !== pl) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%0b f=%0b l=%0b data=%h, need v=1 f=%0b l=%0b data=%h",
                             blk_valid, blk_first, blk_last, blk_data, pf, pl, pd);
                end
            end
            prev_stall = blk_valid && !blk_ready;
            pd = blk_data; pf = blk_first; pl = blk_last;
            if (blk_valid && blk_ready) begin
                n_checks++;
                if (blk_data !== exp_data[0] || blk_first !== exp_first[0] || blk_last !== exp_last[0]) begin
                    n_fail++;
                    $display("FAIL block: got f=%0b l=%0b data=%h, need f=%0b l=%0b data=%h",
                             blk_first, blk_last, blk_data, exp_first[0], exp_last[0], exp_data[0]);
                end
                void'(exp_data.pop_front());
                void'(exp_first.pop_front());
                void'(exp_last.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        blk_ready = 1'b0;
        if (exp_data.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL collect_timeout: got %0d blocks outstanding, need 0", exp_data.size());
            clear_expected();
        end
    endtask

    task automatic run(input logic [7:0] msg[$], input logic trailing,
                       input int gap_pct, input int stall_pct);
        fork
            drive_msg(msg, trailing, gap_pct);
            collect(stall_pct, 6000);
        join
    endtask

    task automatic run_abc_literal();
        logic [7:0] m[$];
        abc_msg(m);
        clear_expected();
        exp_data.push_back({32'h61626380, 416'd0, 64'h18});
        exp_first.push_back(1'b1);
        exp_last.push_back(1'b1);
        run(m, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        in_empty = 1'b0; blk_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_data !== '0 ||
            blk_first !== 1'b0 || blk_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b v=%0b f=%0b l=%0b data_nz=%0b, need all 0",
                     in_ready, blk_valid, blk_first, blk_last, |blk_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got rdy=%0b v=%0b, need rdy=1 v=0", in_ready, blk_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        run_abc_literal();
    endtask

    task automatic test_empty();
        logic [7:0] m[$];
        m.delete();
        clear_expected();
        exp_data.push_back({8'h80, 504'd0});
        exp_first.push_back(1'b1);
        exp_last.push_back(1'b1);
        run(m, 1'b0, 0, 0);
    endtask

    task automatic test_boundaries();
        int lens[12] = '{1, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 0};
        logic [7:0] m[$];
        for (int k = 0; k < 12; k++) begin
            rand_msg(lens[k], m);
            clear_expected();
            add_expected(m);
            run(m, 1'b0, 0, 0);
            rand_msg(lens[k], m);
            add_expected(m);
            run(m, 1'b1, 0, 20);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a[$];
        logic [7:0] b[$];
        rand_msg(64, a);
        abc_msg(b);
        clear_expected();
        add_expected(a);
        add_expected(b);
        fork
            begin
                drive_msg(a, 1'b0, 0);
                drive_msg(b, 1'b0, 0);
            end
            collect(0, 2000);
        join
    endtask

    task automatic test_random();
        logic [7:0] m[$];
        for (int k = 0; k < 15; k++) begin
            rand_msg($urandom_range(150), m);
            clear_expected();
            add_expected(m);
            run(m, 1'($urandom_range(1)), 20, 30);
        end
    endtask

    task automatic test_hold();
        logic [7:0] m[$];
        rand_msg(64, m);
        clear_expected();
        add_expected(m);
        blk_ready = 1'b0;
        drive_msg(m, 1'b0, 0);
        n_checks++;
        if (blk_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL block_latency: got v=%0b, need 1", blk_valid);
        end
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1; in_empty = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_data !== exp_data[0] ||
                blk_first !== 1'b1 || blk_last !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: got v=%0b rdy=%0b f=%0b l=%0b data=%h, need v=1 rdy=0 f=1 l=0 data=%h",
                         blk_valid, in_ready, blk_first, blk_last, blk_data, exp_data[0]);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        collect(0, 100);
        // A beat consumed during the hold would corrupt this block.
        run_abc_literal();
    endtask

    task automatic test_reset_mid();
        logic [7:0] m[$];
        rand_msg(30, m);
        for (int i = 0; i < 30; i++) send_beat(m[i], 1'b0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_abc_literal();

        rand_msg(56, m);
        clear_expected();
        blk_ready = 1'b0;
        drive_msg(m, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_emit: got v=%0b rdy=%0b, need v=0 rdy=1", blk_valid, in_ready);
        end
        @(posedge clk); #1;
        run_abc_literal();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_boundaries();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sha256_padder.md
# sha256_padder

Byte-stream front end for the SHA-256 compression logic. It accepts an arbitrary-length message one byte per beat, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length), and emits 512-bit message blocks. The blocks are presented in the same bit layout the compression core expects on its `message` input. It is the producer side of that 512-bit interface, and it tags each block with first/last flags so a chaining core knows when to load the IV and when a digest is final.

## Interface
- Parameters: none (length field fixed at 64 bits per FIPS 180-4).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  padder can accept a beat.
- `in_data`  in  8  message byte.
- `in_last`  in  1  beat ends the message.
- `in_empty`  in  1  beat carries no byte. Meaningful only with `in_last`, for zero-length messages or a trailing marker.
- `blk_valid`  out  1  `blk_data` holds a block.
- `blk_ready`  in  1  consumer takes block.
- `blk_data`  out  512  block; message byte 0 at [511:504], big-endian.
- `blk_first`  out  1  first block of a message.
- `blk_last`  out  1  final (length-carrying) block of a message.

## Operation
- Two states: FILL and EMIT. A `tail` register holds one of NONE, ZERO_LEN or MARK_LEN.
- FILL:
  - `in_ready`=1.
  - An accepted beat with `in_empty`=0 writes `in_data` at byte index `cnt` (0..63), increments `cnt`, and increments the 61-bit byte-length counter `len` (wraps mod 2^61; overflow not flagged).
  - A beat with `in_empty`=1 writes nothing. It is consumed without effect unless `in_last`=1.
- Let m = bytes in the current block after the beat. Transitions from FILL:
  - m=64 and not last: EMIT the data block, `blk_last`=0, `tail`=NONE.
  - Last beat, m≤55: EMIT one block: data, 0x80 at byte m, zeros, `len*8` in bytes 56..63. `blk_last`=1, `tail`=NONE.
  - Last beat, 56≤m≤63: EMIT data + 0x80 at byte m + zeros, `blk_last`=0, `tail`=ZERO_LEN.
  - Last beat, m=64: EMIT the data block, `blk_last`=0, `tail`=MARK_LEN.
- EMIT:
  - `in_ready`=0. The registered block is held until `blk_valid`&&`blk_ready`.
  - On handshake with `tail`=NONE: go to FILL, clear `cnt`. If the block was last, also clear `len` and set the first-pending flag.
  - On handshake with `tail`=ZERO_LEN: load the block of zeros with `len*8` at bytes 56..63, `blk_last`=1, `tail`=NONE, stay in EMIT.
  - On handshake with `tail`=MARK_LEN: load the same length block with 0x80 at byte 0, `blk_last`=1, `tail`=NONE, stay in EMIT.
- `blk_first`=1 on the first block emitted after reset or after a last block; 0 otherwise. A single-block message has first=last=1.
- Bytes not written by the message are always zero in `blk_data`. Stale buffer contents never leak.

## Timing
- Reset values: state FILL, `cnt`=0, `len`=0, `tail`=NONE, first-pending=1.
- Outputs during reset: `blk_valid`=0, `blk_data`=0, `blk_first`=0, `blk_last`=0. `in_ready`=0 while `rst`=1, and 1 the cycle after.
- Reset mid-message or mid-EMIT discards the partial block, pending tail and length. `blk_valid`=0 the cycle after `rst`.
- Beat accepted at edge t that completes a block: `blk_valid`=1 from t+1. Each pending tail block is valid the cycle after the previous handshake.
- Throughput: 64 byte-cycles plus at least 1 EMIT cycle per full block.
- `in_ready` is a function of state only, never of `in_valid`.
- `blk_valid` stays high until handshake. `blk_data`/`blk_first`/`blk_last` are stable while `blk_valid`&&!`blk_ready`.
- No input beat is accepted in the same cycle as a block handshake.

## Test plan
- "abc" (61,62,63, last on 63) -> one block 61626380 00…00 00000000_00000018, first=last=1. Fed to the compression core it yields digest ba7816bf…f20015ad.
- Empty message (single beat `in_last`=1, `in_empty`=1) -> block 80000000…00, length 0, first=last=1. Digest e3b0c442…7852b855.
- 55-byte message -> one block: byte 55=0x80, bytes 56..63 = 0x1B8, first=last=1. 56-byte "abcdbcde…nopq" -> block0 = data+0x80+zeros (first=1,last=0), block1 = zeros + 0x1C0 (first=0,last=1). Digest 248d6a61…19db06c1.
- 64-byte message -> data block (last=0), then 0x80 00… 0x200 (last=1). A second message follows immediately with first=1 on its first block.
- Hold `blk_ready`=0 for 10 cycles -> `blk_valid` held, block fields unchanged, `in_ready`=0, no bytes consumed.
- Assert `rst` during EMIT with `tail`≠NONE -> `blk_valid`=0 next cycle. The next "abc" produces the exact single block of the first scenario.
